// File: rtl/snake_pkg.sv
// Shared state, direction and sound codes for the snake game sequencer.
package snake_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   localparam logic [1:0] SND_START = 2'd0;
   localparam logic [1:0] SND_EAT   = 2'd1;
   localparam logic [1:0] SND_LEVEL = 2'd2;
   localparam logic [1:0] SND_OVER  = 2'd3;

   function automatic logic [1:0] dir_rev(input logic [1:0] d);
      return d ^ 2'b10;
   endfunction

endpackage

// File: rtl/snake_game_sequencer_if.sv
// Command, data-manager and status bundle of the snake game sequencer.
interface snake_game_sequencer_if #(
   parameter int N  = 16,
   parameter int M  = 2,
   parameter int LW = 3
);
   logic [1:0]    dir_in;
   logic          dir_vld_in;
   logic          sp_evt_in;
   logic          rst_evt_in;
   logic          mode_in;
   logic          food_in;
   logic          col_in;
   logic [1:0]    state_out;
   logic [1:0]    dir_out;
   logic          mv_out;
   logic          grow_out;
   logic          genf_out;
   logic          rst_dm_out;
   logic [N-1:0]  sc_out;
   logic [N-1:0]  hi_out;
   logic [LW-1:0] lvl_out;
   logic [M-1:0]  snd_evt_out;
   logic          snd_trig_out;

   modport master (
      output dir_in, dir_vld_in, sp_evt_in,
      output rst_evt_in, mode_in, food_in, col_in,
      input  state_out, dir_out, mv_out, grow_out,
      input  genf_out, rst_dm_out, sc_out, hi_out,
      input  lvl_out, snd_evt_out, snd_trig_out
   );

   modport slave (
      input  dir_in, dir_vld_in, sp_evt_in,
      input  rst_evt_in, mode_in, food_in, col_in,
      output state_out, dir_out, mv_out, grow_out,
      output genf_out, rst_dm_out, sc_out, hi_out,
      output lvl_out, snd_evt_out, snd_trig_out
   );
endinterface

// File: rtl/snake_dir_queue.sv
// Small direction FIFO; drops duplicates and reversals of the last entry.
module snake_dir_queue
   import snake_pkg::*;
#(
   parameter int DQ = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  logic [1:0] push_dir,
   input  logic [1:0] cur_dir,
   input  logic       pop,
   output logic       empty,
   output logic [1:0] head
);
   localparam int CW = $clog2(DQ + 1);

   logic [1:0]    q [DQ];
   logic [CW-1:0] cnt;
   logic [1:0]    last;
   logic          acc;
   logic          deq;

   // Filter against the newest queued heading, else the live one.
   always_comb begin
      last = cur_dir;
      for (int i = 0; i < DQ; i++)
         if (cnt == CW'(i + 1)) last = q[i];
   end

   assign empty = (cnt == '0);
   assign head  = q[0];
   assign deq   = pop && !empty;
   assign acc   = push && (cnt != CW'(DQ)) &&
                  (push_dir != last) &&
                  (push_dir != dir_rev(last));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         for (int i = 0; i < DQ; i++) q[i] <= DIR_UP;
      end else if (flush) begin
         cnt <= '0;
      end else begin
         if (deq)
            for (int i = 0; i < DQ - 1; i++) q[i] <= q[i+1];
         if (acc)
            for (int i = 0; i < DQ; i++)
               if (CW'(i) == cnt - CW'(deq)) q[i] <= push_dir;
         cnt <= cnt + CW'(acc) - CW'(deq);
      end
   end

endmodule

// File: rtl/snake_game_sequencer.sv
// Snake game controller: state machine, move tick, scoring, levels
// and sound events.
module snake_game_sequencer
   import snake_pkg::*;
#(
   parameter int N           = 16,
   parameter int M           = 2,
   parameter int DQ          = 2,
   parameter int LW          = 3,
   parameter int TICK_BASE   = 10_000_000,
   parameter int TICK_STEP   = 1_000_000,
   parameter int TICK_MIN    = 2_000_000,
   parameter int PTS_PER_LVL = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   snake_game_sequencer_if.slave bus
);
   localparam int CW = $clog2(TICK_BASE);
   localparam int FW = $clog2(PTS_PER_LVL + 1);

   function automatic logic [CW-1:0] reload(
      input logic [LW-1:0] l,
      input logic          m
   );
      longint dec;
      dec = longint'(l) * longint'(TICK_STEP);
      if (!m) return CW'(TICK_BASE - 1);
      if (dec >= longint'(TICK_BASE - TICK_MIN))
         return CW'(TICK_MIN - 1);
      return CW'(longint'(TICK_BASE) - dec - 1);
   endfunction

   state_t        state;
   logic [1:0]    dir;
   logic [N-1:0]  sc, hi;
   logic [LW-1:0] lvl;
   logic [FW-1:0] fcnt;
   logic [CW-1:0] cnt;
   logic          mv, win, grow, genf, gen_pend;
   logic          rst_dm, snd_trig;
   logic [M-1:0]  snd_evt;
   logic          start, flush, tick, live;
   logic          q_empty;
   logic [1:0]    q_head;

   assign live  = (state == ST_RUN) || (state == ST_PAUSE);
   assign start = bus.sp_evt_in && !bus.rst_evt_in &&
                  ((state == ST_IDLE) || (state == ST_OVER));
   assign flush = bus.rst_evt_in || start;
   // A start/pause strobe on the zero count defers the move.
   assign tick  = (state == ST_RUN) && (cnt == '0) &&
                  !bus.sp_evt_in && !bus.rst_evt_in;

   snake_dir_queue #(.DQ(DQ)) u_q (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .push     (bus.dir_vld_in && live),
      .push_dir (bus.dir_in),
      .cur_dir  (dir),
      .pop      (tick),
      .empty    (q_empty),
      .head     (q_head)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         dir      <= DIR_RIGHT;
         sc       <= '0;
         hi       <= '0;
         lvl      <= '0;
         fcnt     <= '0;
         cnt      <= CW'(TICK_BASE - 1);
         mv       <= 1'b0;
         win      <= 1'b0;
         grow     <= 1'b0;
         genf     <= 1'b0;
         gen_pend <= 1'b0;
         rst_dm   <= 1'b0;
         snd_evt  <= '0;
         snd_trig <= 1'b0;
      end else begin
         mv       <= 1'b0;
         win      <= mv;
         grow     <= 1'b0;
         genf     <= gen_pend;
         gen_pend <= 1'b0;
         rst_dm   <= 1'b0;
         snd_trig <= 1'b0;
         if (bus.rst_evt_in) begin
            state  <= ST_IDLE;
            rst_dm <= 1'b1;
            sc     <= '0;
            lvl    <= '0;
            fcnt   <= '0;
            cnt    <= CW'(TICK_BASE - 1);
            win    <= 1'b0;
            genf   <= 1'b0;
         end else begin
            unique case (state)
               ST_IDLE, ST_OVER: if (start) begin
                  state    <= ST_RUN;
                  rst_dm   <= 1'b1;
                  gen_pend <= 1'b1;
                  sc       <= '0;
                  lvl      <= '0;
                  fcnt     <= '0;
                  dir      <= DIR_RIGHT;
                  cnt      <= reload('0, bus.mode_in);
                  win      <= 1'b0;
                  snd_evt  <= M'(SND_START);
                  snd_trig <= 1'b1;
               end
               ST_RUN: begin
                  if (bus.sp_evt_in) begin
                     state <= ST_PAUSE;
                  end else if (cnt == '0) begin
                     mv  <= 1'b1;
                     cnt <= reload(lvl, bus.mode_in);
                     if (!q_empty) dir <= q_head;
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
               ST_PAUSE: if (bus.sp_evt_in) state <= ST_RUN;
            endcase
            // Window response last so collision beats a pause.
            if (win) begin
               if (bus.col_in) begin
                  state    <= ST_OVER;
                  if (sc > hi) hi <= sc;
                  snd_evt  <= M'(SND_OVER);
                  snd_trig <= 1'b1;
               end else if (bus.food_in) begin
                  if (sc != '1) sc <= sc + N'(1);
                  grow     <= 1'b1;
                  genf     <= 1'b1;
                  snd_trig <= 1'b1;
                  if (fcnt == FW'(PTS_PER_LVL - 1)) begin
                     fcnt    <= '0;
                     if (lvl != '1) lvl <= lvl + LW'(1);
                     snd_evt <= M'(SND_LEVEL);
                  end else begin
                     fcnt    <= fcnt + FW'(1);
                     snd_evt <= M'(SND_EAT);
                  end
               end
            end
         end
      end
   end

   assign bus.state_out    = state;
   assign bus.dir_out      = dir;
   assign bus.mv_out       = mv;
   assign bus.grow_out     = grow;
   assign bus.genf_out     = genf;
   assign bus.rst_dm_out   = rst_dm;
   assign bus.sc_out       = sc;
   assign bus.hi_out       = hi;
   assign bus.lvl_out      = lvl;
   assign bus.snd_evt_out  = snd_evt;
   assign bus.snd_trig_out = snd_trig;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Bench for snake_game_sequencer: sound events through a scoreboard,
// tick timing, direction filtering and state checks inline.
`timescale 1ns/1ps
module tb_snake_game_sequencer;
   import snake_pkg::*;

   localparam int N  = 4;
   localparam int M  = 2;
   localparam int LW = 3;

   typedef struct packed {
      logic [1:0]    evt;
      logic [N-1:0]  sc;
      logic [LW-1:0] lvl;
      logic [1:0]    st;
   } snd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   foods = 0;
   snd_t sb [$];
   snd_t m_got, m_exp;

   snake_game_sequencer_if #(.N(N), .M(M), .LW(LW)) bus ();

   snake_game_sequencer #(
      .N(N), .M(M), .DQ(2), .LW(LW),
      .TICK_BASE(20), .TICK_STEP(4), .TICK_MIN(8),
      .PTS_PER_LVL(5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic snd_t mk(input int e, input int s,
                               input int l, input int st);
      snd_t r;
      r.evt = 2'(e);
      r.sc  = N'(s);
      r.lvl = LW'(l);
      r.st  = 2'(st);
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst && bus.snd_trig_out) begin
         m_got = {bus.snd_evt_out, bus.sc_out,
                  bus.lvl_out, bus.state_out};
         if (sb.size() == 0) begin
            check("snd_unexp", 32'(sb.size()), 1);
         end else begin
            m_exp = sb.pop_front();
            check("snd", 32'(m_got), 32'(m_exp));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_mv(output int t);
      t = cyc;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.mv_out) begin
            t = cyc;
            return;
         end
      end
      check("mv_timeout", 32'(bus.mv_out), 1);
   endtask

   task automatic send_dir(input logic [1:0] d);
      bus.dir_in     = d;
      bus.dir_vld_in = 1'b1;
      tick();
      bus.dir_vld_in = 1'b0;
   endtask

   // Called in the mv cycle; drives flags in mv+1, checks mv+2.
   task automatic window(input logic f, input logic c, input snd_t e);
      tick();
      bus.food_in = f;
      bus.col_in  = c;
      sb.push_back(e);
      tick();
      bus.food_in = 1'b0;
      bus.col_in  = 1'b0;
      check("grow", 32'(bus.grow_out), 32'(f && !c));
      check("genf", 32'(bus.genf_out), 32'(f && !c));
   endtask

   task automatic eat();
      int s, l;
      foods++;
      s = (foods > 15) ? 15 : foods;
      l = (foods / 5 > 7) ? 7 : foods / 5;
      window(1'b1, 1'b0, mk((foods % 5 == 0) ? 2 : 1, s, l, 1));
      check("eat_sc", 32'(bus.sc_out), 32'(s));
      check("eat_lvl", 32'(bus.lvl_out), 32'(l));
   endtask

   task automatic start_game();
      sb.push_back(mk(0, 0, 0, 1));
      foods = 0;
      bus.sp_evt_in = 1'b1;
      tick();
      bus.sp_evt_in = 1'b0;
      check("st_rstdm", 32'(bus.rst_dm_out), 1);
      check("st_state", 32'(bus.state_out), 1);
      check("st_dir", 32'(bus.dir_out), 1);
      check("st_sc", 32'(bus.sc_out), 0);
   endtask

   initial begin
      int t0, t1, t2, n;
      bus.dir_in     = 2'd0;
      bus.dir_vld_in = 1'b0;
      bus.sp_evt_in  = 1'b0;
      bus.rst_evt_in = 1'b0;
      bus.mode_in    = 1'b0;
      bus.food_in    = 1'b0;
      bus.col_in     = 1'b0;
      ticks(3);
      check("rst_state", 32'(bus.state_out), 0);
      check("rst_dir", 32'(bus.dir_out), 1);
      check("rst_sc", 32'(bus.sc_out), 0);
      check("rst_hi", 32'(bus.hi_out), 0);
      check("rst_lvl", 32'(bus.lvl_out), 0);
      check("rst_mv", 32'(bus.mv_out), 0);
      check("rst_snd", 32'(bus.snd_evt_out), 0);
      rst = 1'b0;
      ticks(2);
      check("idle_hold", 32'(bus.state_out), 0);

      start_game();
      t0 = cyc;
      check("genf_early", 32'(bus.genf_out), 0);
      tick();
      check("rstdm_drop", 32'(bus.rst_dm_out), 0);
      check("genf_pulse", 32'(bus.genf_out), 1);
      tick();
      check("genf_drop", 32'(bus.genf_out), 0);
      wait_mv(t1);
      check("first_mv", 32'(t1 - t0), 20);
      wait_mv(t2);
      check("period0", 32'(t2 - t1), 20);

      send_dir(2'd3);
      wait_mv(t1);
      check("rev_drop", 32'(bus.dir_out), 1);
      send_dir(2'd0);
      send_dir(2'd3);
      wait_mv(t1);
      check("dir_q0", 32'(bus.dir_out), 0);
      wait_mv(t1);
      check("dir_q1", 32'(bus.dir_out), 3);

      wait_mv(t1);
      eat();
      wait_mv(t1);
      window(1'b0, 1'b1, mk(3, 1, 0, 3));
      check("col_state", 32'(bus.state_out), 3);
      check("col_hi", 32'(bus.hi_out), 1);
      n = 0;
      repeat (30) begin
         tick();
         if (bus.mv_out) n++;
      end
      check("over_no_mv", 32'(n), 0);

      start_game();
      check("hi_kept", 32'(bus.hi_out), 1);
      repeat (3) begin
         wait_mv(t1);
         eat();
      end
      wait_mv(t1);
      window(1'b1, 1'b1, mk(3, 3, 0, 3));
      check("cf_state", 32'(bus.state_out), 3);
      check("cf_sc", 32'(bus.sc_out), 3);
      check("cf_hi", 32'(bus.hi_out), 3);

      bus.mode_in = 1'b1;
      start_game();
      repeat (5) begin
         wait_mv(t1);
         eat();
      end
      wait_mv(t1);
      wait_mv(t2);
      check("period1", 32'(t2 - t1), 16);

      ticks(15);
      bus.sp_evt_in = 1'b1;
      tick();
      bus.sp_evt_in = 1'b0;
      check("pz_state", 32'(bus.state_out), 2);
      check("pz_mv", 32'(bus.mv_out), 0);
      n = 0;
      repeat (50) begin
         tick();
         if (bus.mv_out) n++;
      end
      check("pz_no_mv", 32'(n), 0);
      bus.sp_evt_in = 1'b1;
      tick();
      bus.sp_evt_in = 1'b0;
      check("rs_state", 32'(bus.state_out), 1);
      tick();
      check("rs_mv", 32'(bus.mv_out), 1);

      repeat (11) begin
         wait_mv(t1);
         eat();
      end
      check("sat_sc", 32'(bus.sc_out), 15);

      bus.rst_evt_in = 1'b1;
      bus.sp_evt_in  = 1'b1;
      tick();
      bus.rst_evt_in = 1'b0;
      bus.sp_evt_in  = 1'b0;
      check("re_state", 32'(bus.state_out), 0);
      check("re_rstdm", 32'(bus.rst_dm_out), 1);
      check("re_sc", 32'(bus.sc_out), 0);
      check("re_lvl", 32'(bus.lvl_out), 0);
      check("re_hi", 32'(bus.hi_out), 3);
      ticks(5);
      check("re_idle", 32'(bus.state_out), 0);

      start_game();
      ticks(5);
      #3;
      rst = 1'b1;
      #1;
      check("ar_state", 32'(bus.state_out), 0);
      check("ar_hi", 32'(bus.hi_out), 0);
      check("ar_dir", 32'(bus.dir_out), 1);
      check("ar_rstdm", 32'(bus.rst_dm_out), 0);
      ticks(2);
      rst = 1'b0;
      ticks(2);
      check("sb_left", 32'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
